fetch_pc: RTL and testbench

Parametrised fetch-stage program counter. It is the successor to the plain PC register and its +4 incrementer. Each cycle it selects the next fetch address from trap, redirect, stall, predicted call, predicted return, or sequential increment, and it keeps a circular return-address stack (RAS) of configurable depth. It sits between the instruction-memory address port and the decode/execute redirect paths.

---
 rtl/fetch_pc_if.sv | 27 ++
 rtl/fetch_pc.sv | 87 ++++++++
 tb/tb_fetch_pc.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - fetch PC control/observation bundle
interface fetch_pc_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             trap;
    logic             redirect;
    logic [WIDTH-1:0] redirect_addr;
    logic             is_call;
    logic [WIDTH-1:0] call_target;
    logic             is_ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output stall, trap, redirect, redirect_addr, is_call, call_target, is_ret,
        input  pc, pc_inc, ras_top, ras_empty, ras_full
    );

    modport slave (
        input  stall, trap, redirect, redirect_addr, is_call, call_target, is_ret,
        output pc, pc_inc, ras_top, ras_empty, ras_full
    );
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - fetch program counter with circular return-address stack
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module fetch_pc #(
    parameter int               WIDTH      = `WORDSIZE,
    parameter int               INC        = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int               RAS_DEPTH  = 4
) (
    input logic        CLK,
    input logic        reset,
    fetch_pc_if.slave  bus
);
    localparam int               PW    = $clog2(RAS_DEPTH);
    localparam int               CW    = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    tos_q, tos_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             push;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top;

    assign pc_inc = pc_q + INC_W;
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL);
    assign top    = empty ? '0 : ras_q[tos_q];

    assign bus.pc        = pc_q;
    assign bus.pc_inc    = pc_inc;
    assign bus.ras_top   = top;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;

    // Strict priority: trap > redirect > stall > call > return > sequential.
    always_comb begin
        pc_d  = pc_inc;
        tos_d = tos_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (bus.trap) begin
            pc_d  = TRAP_VEC;
            tos_d = '0;
            cnt_d = '0;
        end else if (bus.redirect) begin
            pc_d = bus.redirect_addr;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.is_call) begin
            pc_d  = bus.call_target;
            push  = 1'b1;
            tos_d = tos_q + PW'(1);
            cnt_d = full ? cnt_q : cnt_q + CW'(1);
        end else if (bus.is_ret && !empty) begin
            pc_d  = top;
            tos_d = tos_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // A full-stack push lands on the oldest slot, so overflow drops the oldest return.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_ADDR;
            tos_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            if (push) begin
                ras_q[tos_d] <= pc_inc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - vector, corner-case and randomized checks for fetch_pc
module tb_fetch_pc;
    localparam int DEPTH = 4;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    fetch_pc_if #(.WIDTH(32)) bus ();

    fetch_pc #(
        .WIDTH(32), .INC(4), .RESET_ADDR(32'h0), .TRAP_VEC(TRAP), .RAS_DEPTH(DEPTH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        st;
        logic        tr;
        logic        rd;
        logic [31:0] ra;
        logic        ca;
        logic [31:0] ct;
        logic        rt;
        logic [31:0] epc;
        logic [31:0] etop;
        logic        eemp;
        logic        efull;
    } vec_t;

    vec_t tbl [25];

    // Reference model: plain PC plus a bounded queue used as the return stack.
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic st, input logic tr, input logic rd, input logic [31:0] ra,
                         input logic ca, input logic [31:0] ct, input logic rt);
        bus.stall = st; bus.trap = tr; bus.redirect = rd; bus.redirect_addr = ra;
        bus.is_call = ca; bus.call_target = ct; bus.is_ret = rt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] etop,
                             input logic eemp, input logic efull);
        chk({tag, ".pc"}, bus.pc, epc);
        chk({tag, ".pc_inc"}, bus.pc_inc, epc + 32'd4);
        chk({tag, ".ras_top"}, bus.ras_top, etop);
        chk({tag, ".ras_empty"}, {31'b0, bus.ras_empty}, {31'b0, eemp});
        chk({tag, ".ras_full"}, {31'b0, bus.ras_full}, {31'b0, efull});
    endtask

    function automatic vec_t mk(input logic st, input logic tr, input logic rd, input logic [31:0] ra,
                                input logic ca, input logic [31:0] ct, input logic rt,
                                input logic [31:0] epc, input logic [31:0] etop,
                                input logic eemp, input logic efull);
        vec_t v;
        v.st = st; v.tr = tr; v.rd = rd; v.ra = ra; v.ca = ca; v.ct = ct; v.rt = rt;
        v.epc = epc; v.etop = etop; v.eemp = eemp; v.efull = efull;
        return v;
    endfunction

    task automatic model_step(input logic st, input logic tr, input logic rd, input logic [31:0] ra,
                              input logic ca, input logic [31:0] ct, input logic rt);
        if (tr) begin
            m_pc = TRAP;
            m_ras.delete();
        end else if (rd) begin
            m_pc = ra;
        end else if (st) begin
            m_pc = m_pc;
        end else if (ca) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            m_pc = ct;
        end else if (rt && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,32'h0,  0,32'h0,  0, 32'h004, 32'h0,   1,0);
        tbl[1]  = mk(0,0,0,32'h0,  0,32'h0,  0, 32'h008, 32'h0,   1,0);
        tbl[2]  = mk(0,0,0,32'h0,  0,32'h0,  0, 32'h00c, 32'h0,   1,0);
        tbl[3]  = mk(0,0,1,32'h10, 0,32'h0,  0, 32'h010, 32'h0,   1,0);
        tbl[4]  = mk(0,0,0,32'h0,  1,32'h200,0, 32'h200, 32'h014, 0,0);
        tbl[5]  = mk(0,0,0,32'h0,  1,32'h300,0, 32'h300, 32'h204, 0,0);
        tbl[6]  = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h204, 32'h014, 0,0);
        tbl[7]  = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h014, 32'h0,   1,0);
        tbl[8]  = mk(0,0,1,32'h0,  0,32'h0,  0, 32'h000, 32'h0,   1,0);
        tbl[9]  = mk(0,0,0,32'h0,  1,32'h100,0, 32'h100, 32'h004, 0,0);
        tbl[10] = mk(0,0,0,32'h0,  1,32'h200,0, 32'h200, 32'h104, 0,0);
        tbl[11] = mk(0,0,0,32'h0,  1,32'h300,0, 32'h300, 32'h204, 0,0);
        tbl[12] = mk(0,0,0,32'h0,  1,32'h400,0, 32'h400, 32'h304, 0,1);
        tbl[13] = mk(0,0,0,32'h0,  1,32'h500,0, 32'h500, 32'h404, 0,1);
        tbl[14] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h404, 32'h304, 0,0);
        tbl[15] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h304, 32'h204, 0,0);
        tbl[16] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h204, 32'h104, 0,0);
        tbl[17] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h104, 32'h0,   1,0);
        tbl[18] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h108, 32'h0,   1,0);
        tbl[19] = mk(0,0,0,32'h0,  1,32'h40, 0, 32'h040, 32'h10c, 0,0);
        tbl[20] = mk(1,1,1,32'h80, 1,32'h700,0, TRAP,    32'h0,   1,0);
        tbl[21] = mk(1,0,1,32'h80, 0,32'h0,  0, 32'h080, 32'h0,   1,0);
        tbl[22] = mk(1,0,0,32'h0,  1,32'h900,0, 32'h080, 32'h0,   1,0);
        tbl[23] = mk(0,0,0,32'h0,  1,32'h600,1, 32'h600, 32'h084, 0,0);
        tbl[24] = mk(0,0,0,32'h0,  0,32'h0,  1, 32'h084, 32'h0,   1,0);

        idle();
        #12;
        chk_state("reset", 32'h0, 32'h0, 1, 0);
        @(negedge CLK);
        reset = 1'b1;
        step();
        chk_state("first_edge", 32'h4, 32'h0, 1, 0);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        chk_state("rearm", 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].st, tbl[i].tr, tbl[i].rd, tbl[i].ra, tbl[i].ct != 0 && tbl[i].ca,
                  tbl[i].ct, tbl[i].rt);
            step();
            chk_state($sformatf("vec%0d", i), tbl[i].epc, tbl[i].etop, tbl[i].eemp, tbl[i].efull);
        end

        // Stall across the 32-bit wrap point.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        step();
        chk("wrap.pc", bus.pc, 32'hFFFF_FFFC);
        chk("wrap.pc_inc", bus.pc_inc, 32'h0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        step();
        chk("wrap.stall1", bus.pc, 32'hFFFF_FFFC);
        step();
        chk("wrap.stall2", bus.pc, 32'hFFFF_FFFC);
        idle();
        step();
        chk("wrap.release", bus.pc, 32'h0);

        // Asynchronous reset with two entries on the stack.
        drive(0, 0, 0, 32'h0, 1, 32'h50, 0);
        step();
        drive(0, 0, 0, 32'h0, 1, 32'h60, 0);
        step();
        idle();
        chk_state("pre_areset", 32'h60, 32'h54, 0, 0);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk_state("areset", 32'h0, 32'h0, 1, 0);
        step();
        chk_state("areset_hold", 32'h0, 32'h0, 1, 0);
        @(negedge CLK);
        reset = 1'b1;
        step();
        chk_state("areset_release", 32'h4, 32'h0, 1, 0);

        // Randomized run against the reference model.
        m_pc = bus.pc;
        m_ras.delete();
        for (int i = 0; i < 600; i++) begin
            logic st, tr, rd, ca, rt;
            logic [31:0] ra, ct;
            tr = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 7) == 0);
            ca = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 2) == 0);
            ra = $urandom & 32'hFFFF_FFFC;
            ct = $urandom & 32'hFFFF_FFFC;
            drive(st, tr, rd, ra, ca, ct, rt);
            model_step(st, tr, rd, ra, ca, ct, rt);
            step();
            chk_state($sformatf("rnd%0d", i), m_pc,
                      (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1],
                      m_ras.size() == 0, m_ras.size() == DEPTH);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
